// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit adder. One bit pair per cycle, LSB first, through a
// full-adder slice made of two gate-level half adders and an OR gate, with a
// registered carry. Results appear on the outputs only when the operation
// completes.
//
// Handshake: start is sampled only in IDLE. An accepted start captures A, B
// and Cin. busy is high for exactly WIDTH cycles. done then pulses for one
// cycle, and Sum/Cout/overflow/zero are valid from that cycle on. A start
// seen while busy or done is dropped and is not queued.

// Gate-level half adder primitive.
module serial_add_unit_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Full-adder slice: two half adders plus an OR produce the sum bit and
  // the carry into the next bit position.
  logic             ha0_s, ha0_c;
  logic             ha1_s, ha1_c;
  logic             slice_s, slice_c;
  logic [WIDTH-1:0] res_shift;

  serial_add_unit_ha u_ha0 (
    .a (a_q[0]),
    .b (b_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  serial_add_unit_ha u_ha1 (
    .a (ha0_s),
    .b (carry_q),
    .s (ha1_s),
    .c (ha1_c)
  );

  assign slice_s = ha1_s;
  assign slice_c = ha0_c | ha1_c;

  // Result register after this cycle's bit has been shifted in from the MSB
  // end. On the last RUN cycle this is the completed sum.
  assign res_shift = (res_q >> 1) | {slice_s, {(WIDTH-1){1'b0}}};

  // Next-state logic and datapath updates. Every signal defaults to holding.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shift;
        carry_d = slice_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB slice, and slice_c is the
          // carry out of it. The outputs load on the same edge that enters
          // DONE, so they are valid in the cycle where done is high.
          sum_d   = res_shift;
          cout_d  = slice_c;
          ovf_d   = carry_q ^ slice_c;
          zero_d  = (res_shift == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, with an asynchronous active-low clear.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Bench for serial_add_unit. Expected results come from a behavioural
// A+B+Cin model and go into a queue when a start is driven. They are popped
// when done is observed. Outputs are sampled on the falling clock edge.
module tb_serial_add_unit;
  localparam int W     = 64;
  localparam int CNT_W = 7;

  logic         CLK = 1'b0;
  logic         Reset_L;
  logic         start;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         busy, done;
  logic [W-1:0] Sum;
  logic         Cout, overflow, zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_f_q[$];   // {Cout, overflow, zero}
  logic [W-1:0] last_sum;
  logic [2:0]   last_f;

  serial_add_unit #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .Reset_L  (Reset_L),
    .start    (start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .busy     (busy),
    .done     (done),
    .Sum      (Sum),
    .Cout     (Cout),
    .overflow (overflow),
    .zero     (zero)
  );

  // clock
  always #5 CLK = ~CLK;

  // model: push the expected result of a+b+cin
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         v;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    s    = full[W-1:0];
    v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    exp_q.push_back(s);
    exp_f_q.push_back({full[W], v, (s == '0)});
  endtask

  task automatic test_reset();
    Reset_L = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(posedge CLK);
    #3 Reset_L = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, Cout, overflow, zero} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, Cout, overflow, zero});
    end
    n_checks++;
    if (Sum !== '0) begin
      n_fail++;
      $display("FAIL reset_sum: got %h expected 0", Sum);
    end
    repeat (2) @(negedge CLK);
    Reset_L = 1'b1;
    last_sum = '0;
    last_f   = '0;
  endtask

  // Drive one addition, watch busy/done timing and pop the result on done.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input string name);
    int busy_bad = 0;
    int sum_bad  = 0;
    int done_cnt = 0;
    int done_at  = -1;
    logic [W-1:0] es;
    logic [2:0]   ef;
    @(negedge CLK);
    A = a; B = b; Cin = cin; start = 1'b1;
    push_exp(a, b, cin);
    for (int cyc = 1; cyc <= W + 2; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      if (cyc == 10) begin
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; Cin = ~cin;
      end
      if (cyc == 20) start = 1'b1;   // start during RUN is ignored
      if (busy !== (cyc <= W)) busy_bad++;
      if (cyc <= W && (Sum !== last_sum || {Cout, overflow, zero} !== last_f)) sum_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_queue: done with no expected result", name);
        end else begin
          es = exp_q.pop_front();
          ef = exp_f_q.pop_front();
          if (Sum !== es) begin
            n_fail++;
            $display("FAIL %s_sum: got %h expected %h", name, Sum, es);
          end
          n_checks++;
          if ({Cout, overflow, zero} !== ef) begin
            n_fail++;
            $display("FAIL %s_flags: got cout/ovf/zero %b expected %b", name, {Cout, overflow, zero}, ef);
          end
          last_sum = es;
          last_f   = ef;
        end
      end
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s_busy: %0d bad cycles expected 0", name, busy_bad);
    end
    n_checks++;
    if (done_cnt != 1 || done_at != W + 1) begin
      n_fail++;
      $display("FAIL %s_done: got %0d pulses at cycle %0d expected 1 at %0d", name, done_cnt, done_at, W + 1);
    end
    n_checks++;
    if (sum_bad != 0) begin
      n_fail++;
      $display("FAIL %s_partial: outputs changed in %0d RUN cycles expected 0", name, sum_bad);
    end
    n_checks++;
    if (Sum !== last_sum) begin
      n_fail++;
      $display("FAIL %s_hold: got %h expected %h", name, Sum, last_sum);
    end
  endtask

  task automatic test_simple();
    do_add(64'd5, 64'd3, 1'b0, "simple");
  endtask

  task automatic test_wrap();
    do_add({W{1'b1}}, 64'd1, 1'b0, "wrap_ones");
    do_add(64'd0, 64'd0, 1'b1, "wrap_cin");
  endtask

  task automatic test_signed_ovf();
    do_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "ovf_pos");
    do_add(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "ovf_neg");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      do_add({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), "random");
  endtask

  // start held high for the whole window; A changes mid-run.
  task automatic test_handshake();
    logic [W-1:0] bv;
    logic [W-1:0] es;
    logic [2:0]   ef;
    int done_cnt = 0;
    int first_at = -1;
    int second_at = -1;
    bv = {$urandom, $urandom};
    @(negedge CLK);
    A = 64'd10; B = bv; Cin = 1'b0; start = 1'b1;
    push_exp(64'd10, bv, 1'b0);
    for (int cyc = 1; cyc <= 2 * W + 8; cyc++) begin
      @(negedge CLK);
      if (cyc == 20) A = 64'd99;
      if (cyc == 2 * W + 3) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_at = cyc;
          push_exp(64'd99, bv, 1'b0);
        end else begin
          second_at = cyc;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL hs_queue: done with no expected result");
        end else begin
          es = exp_q.pop_front();
          ef = exp_f_q.pop_front();
          if (Sum !== es || {Cout, overflow, zero} !== ef) begin
            n_fail++;
            $display("FAIL hs_result%0d: got %h/%b expected %h/%b", done_cnt, Sum, {Cout, overflow, zero}, es, ef);
          end
          last_sum = es;
          last_f   = ef;
        end
      end
    end
    n_checks++;
    if (done_cnt != 2 || first_at != W + 1 || second_at != 2 * W + 3) begin
      n_fail++;
      $display("FAIL hs_timing: got %0d pulses at %0d,%0d expected 2 at %0d,%0d",
               done_cnt, first_at, second_at, W + 1, 2 * W + 3);
    end
  endtask

  // Reset in the middle of RUN, then a fresh operation.
  task automatic test_abort();
    int done_cnt = 0;
    @(negedge CLK);
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; Cin = 1'b1; start = 1'b1;
    push_exp(A, B, Cin);
    for (int cyc = 1; cyc < 30; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      if (done === 1'b1) done_cnt++;
    end
    #2 Reset_L = 1'b0;
    #1;
    exp_q.delete();
    exp_f_q.delete();
    last_sum = '0;
    last_f   = '0;
    n_checks++;
    if ({busy, done, Cout, overflow, zero} !== 5'b0 || Sum !== '0) begin
      n_fail++;
      $display("FAIL abort_reset: got busy/done/c/v/z %b sum %h expected all 0",
               {busy, done, Cout, overflow, zero}, Sum);
    end
    repeat (2) @(negedge CLK);
    Reset_L = 1'b1;
    for (int cyc = 0; cyc < W + 10; cyc++) begin
      @(negedge CLK);
      if (done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_nodone: got %0d pulses expected 0", done_cnt);
    end
    do_add(64'd7, 64'd8, 1'b0, "abort_next");
  endtask

  initial begin
    test_reset();
    test_simple();
    test_wrap();
    test_signed_ovf();
    test_random();
    test_handshake();
    test_abort();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_empty: %0d results never produced expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
- Bit-serial WIDTH-bit adder built around the team's gate-level half adder. Each cycle it processes one bit pair, LSB first, through a full-adder slice made of two half adders plus an OR, with a registered carry.
- Sits downstream of the half adder primitive and upstream of the ALU result mux. It trades latency for minimal gate count.
- Uses a start/busy/done handshake and produces Sum, Cout, overflow and zero flags.

Parameters:
- WIDTH, 64: operand and result width in bits; must be >= 2.
- CNT_W, 7: bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepted start.
- B  input  WIDTH  operand B; captured on the accepted start.
- Cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse when results become valid.
- Sum  output  WIDTH  registered result A+B+Cin modulo 2^WIDTH.
- Cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  high when Sum == 0.

Behaviour:
- One clock domain: CLK. Reset_L is asynchronous and active-low.
- Reset (Reset_L=0, asynchronous, takes effect immediately):
  - state=IDLE.
  - busy, done, Sum, Cout, overflow, zero all 0.
  - Internal shift registers, carry and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: load shift registers with A and B, carry<=Cin, count<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - busy=1 each cycle.
  - Slice: s = a0^b0^c; c_next = (a0&b0)|(c&(a0^b0)).
  - Shift A and B right by one; shift s into the internal result register from the MSB end; carry<=c_next; count<=count+1.
  - When count==WIDTH-1, also latch cmsb<=c, the carry into the MSB slice.
  - After the cycle with count==WIDTH-1, go to DONE. RUN lasts exactly WIDTH cycles.
- DONE (one cycle):
  - busy=0, done=1.
  - On entry edge, load output registers: Sum<=completed result register, Cout<=carry, overflow<=cmsb^carry, zero<=(completed result==0).
  - Next state is IDLE, unconditionally.
- Timing: start sampled at edge k → busy high for cycles k+1..k+WIDTH → done high in cycle k+WIDTH+1 → earliest next accepted start at edge k+WIDTH+2.
- Output holding: Sum, Cout, overflow and zero hold their values from DONE until the next DONE or reset. Partial results are never visible on the outputs.
- start=1 during RUN or DONE is ignored. It does not queue and does not extend the operation.
- Changes on A, B or Cin after the accepted start have no effect on the current result.
- Reset_L low mid-RUN aborts the operation: no done pulse, and outputs return to reset values.
- Arithmetic is unsigned modulo 2^WIDTH. Cout and overflow are both provided so the ALU can derive both unsigned (C) and signed (V) flags.

Test Plan:
- Reset: Reset_L=0 asynchronously, mid-cycle → busy=done=Sum=Cout=overflow=zero=0 with no clock edge required.
- Simple add (WIDTH=64): A=5, B=3, Cin=0, start pulsed at edge k → busy cycles k+1..k+64; done=1 only in cycle k+65; Sum=8, Cout=0, overflow=0, zero=0.
- Unsigned wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=1, Cin=0 → Sum=0, Cout=1, zero=1, overflow=0. Then A=0, B=0, Cin=1 → Sum=1, Cout=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1 → Sum=0x8000_0000_0000_0000, overflow=1, Cout=0. Also A=B=0x8000_0000_0000_0000 → Sum=0, Cout=1, overflow=1, zero=1.
- Handshake: start held high throughout, with A changed from 10 to 99 at cycle k+20 → exactly one done in cycle k+65 with Sum=10+B. Next done arrives in cycle k+131, since the start at edge k+66 is accepted; DONE-cycle start is ignored.
- Abort: Reset_L=0 for 2 cycles at cycle k+30, then start with A=7, B=8 → no done from the aborted operation; new result Sum=15 with done 65 cycles after the new start.
